// File: rtl/level_manager_pkg.sv
// Shared definitions for the level_manager game sequencer: FSM state
// encoding, per-ball-size point values, the level table and the
// points lookup used by the score accumulator.
package level_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DEPLOY    = 3'd1,
      REARM     = 3'd2,
      PLAY      = 3'd3,
      HIT       = 3'd4,
      CLEAR     = 3'd5,
      GAME_OVER = 3'd6,
      WIN       = 3'd7
   } state_t;

   // Points awarded for popping one ball of each size.
   localparam logic [15:0] PTS_SMALL  = 16'd50;
   localparam logic [15:0] PTS_MEDIUM = 16'd100;
   localparam logic [15:0] PTS_BIG    = 16'd200;
   localparam logic [15:0] PTS_HUGE   = 16'd400;

   // One level: which units are enabled and the starting ball size of each.
   // A disabled unit always carries a starting size of 0.
   typedef struct packed {
      logic [1:0] mask;
      logic [1:0] init0;
      logic [1:0] init1;
   } level_entry_t;

   localparam level_entry_t LEVEL_TABLE [4] = '{
      '{mask: 2'b01, init0: 2'd1, init1: 2'd0},
      '{mask: 2'b01, init0: 2'd2, init1: 2'd0},
      '{mask: 2'b11, init0: 2'd2, init1: 2'd2},
      '{mask: 2'b11, init0: 2'd3, init1: 2'd2}
   };

   function automatic logic [15:0] points_of(input logic [1:0] ball_type);
      logic [15:0] pts;
      case (ball_type)
         2'd0:    pts = PTS_SMALL;
         2'd1:    pts = PTS_MEDIUM;
         2'd2:    pts = PTS_BIG;
         2'd3:    pts = PTS_HUGE;
         default: pts = 16'd0;
      endcase
      return pts;
   endfunction

endpackage

// File: rtl/level_manager_score_accumulator.sv
// Saturating 16-bit score register fed by up to two pop events per cycle.
// With LEVEL_MANAGER_BONUS_LIFE_EN defined, o_bonus flags a cycle in which
// the update raises score[15:12]; otherwise o_bonus is tied low.
module score_accumulator
   import level_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            i_clear,
   input  logic [1:0]      i_event,
   input  logic [1:0][1:0] i_type,
   output logic [15:0]     o_score,
   output logic            o_bonus
);

   logic [15:0] r_score;
   logic [15:0] w_pts0;
   logic [15:0] w_pts1;
   logic [16:0] w_sum;
   logic [15:0] w_next;

   // Sum both units' points onto the current score and clamp at 16'hFFFF.
   always_comb begin
      if (i_event[0]) begin
         w_pts0 = points_of(i_type[0]);
      end else begin
         w_pts0 = 16'd0;
      end
      if (i_event[1]) begin
         w_pts1 = points_of(i_type[1]);
      end else begin
         w_pts1 = 16'd0;
      end
      w_sum = {1'b0, r_score} + {1'b0, w_pts0} + {1'b0, w_pts1};
      if (w_sum[16]) begin
         w_next = 16'hFFFF;
      end else begin
         w_next = w_sum[15:0];
      end
   end

`ifdef LEVEL_MANAGER_BONUS_LIFE_EN
   // Bonus strobe when the top nibble of the score moves upward.
   always_comb begin
      if (!i_clear && (w_next[15:12] > r_score[15:12])) begin
         o_bonus = 1'b1;
      end else begin
         o_bonus = 1'b0;
      end
   end
`else
   assign o_bonus = 1'b0;
`endif

   // Score register: cleared by reset or game start, else takes the new sum.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_score <= 16'd0;
      end else if (i_clear) begin
         r_score <= 16'd0;
      end else begin
         r_score <= w_next;
      end
   end

   assign o_score = r_score;

endmodule

// File: rtl/level_manager.sv
// level_manager: game-level sequencer driving two ball controller units.
// Sequences deploy -> play -> hit/clear -> next level / game over and keeps
// score, lives and level. Optional bonus-life feature is enabled by defining
// LEVEL_MANAGER_BONUS_LIFE_EN.
module level_manager
   import level_pkg::*;
#(
   parameter int unsigned LIVES_INIT  = 3,
   parameter int unsigned NUM_LEVELS  = 4,
   parameter int unsigned HIT_HOLD    = 25_000_000,
   parameter int unsigned ARM_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            startGame,
   input  logic [1:0]      col_rope_ball,
   input  logic [1:0][1:0] col_ball_type,
   input  logic [1:0]      col_player_ball,
   input  logic [1:0]      inUse,
   output logic [1:0]      unitActive,
   output logic [1:0][1:0] initialState,
   output logic [15:0]     score,
   output logic [2:0]      lives,
   output logic [1:0]      level,
   output logic            playerHitPulse,
   output logic            gameOver,
   output logic            levelWon
);

   localparam logic [2:0]  LIVES_LOAD = 3'(LIVES_INIT);
   localparam logic [1:0]  LAST_LEVEL = 2'(NUM_LEVELS - 1);
   localparam logic [31:0] HOLD_LAST  = 32'(HIT_HOLD - 1);
   localparam logic [31:0] ARM_LAST   = 32'(ARM_TIMEOUT - 1);

   state_t       r_state;
   state_t       w_next_state;
   logic [31:0]  r_cnt;
   logic [1:0]   r_level;
   logic [1:0]   w_next_level;
   logic [2:0]   r_lives;
   logic [2:0]   w_next_lives;
   logic [3:0]   w_lives_sum;
   logic [1:0]   r_unit_active;
   logic [1:0][1:0] r_initial_state;
   logic         r_hit_pulse;
   logic         r_game_over;
   logic         r_level_won;

   logic [1:0]   w_mask;
   logic         w_in_play;
   logic         w_start;
   logic         w_hit;
   logic [1:0]   w_rope_ev;
   logic         w_all_up;
   logic         w_all_down;
   logic         w_bonus;
   level_entry_t w_next_entry;
   logic         w_next_armed;
   logic         w_next_loaded;

   // Decode the current level's enable mask and qualify inputs by state.
   always_comb begin
      w_mask     = LEVEL_TABLE[r_level].mask;
      w_in_play  = (r_state == PLAY);
      w_start    = startGame && ((r_state == IDLE) || (r_state == GAME_OVER) ||
                                 (r_state == WIN));
      w_hit      = w_in_play && (col_player_ball != 2'b00);
      if (w_in_play) begin
         w_rope_ev = col_rope_ball;
      end else begin
         w_rope_ev = 2'b00;
      end
      w_all_up   = ((inUse & w_mask) == w_mask);
      w_all_down = ((inUse & w_mask) == 2'b00);
   end

   // Next-state and next-level logic for the game sequencer.
   always_comb begin
      w_next_state = r_state;
      w_next_level = r_level;
      case (r_state)
         IDLE, GAME_OVER, WIN: begin
            if (startGame) begin
               w_next_state = DEPLOY;
               w_next_level = 2'd0;
            end else begin
               w_next_state = r_state;
            end
         end
         DEPLOY: begin
            if (w_all_up) begin
               w_next_state = PLAY;
            end else if (r_cnt == ARM_LAST) begin
               w_next_state = REARM;
            end else begin
               w_next_state = DEPLOY;
            end
         end
         REARM: begin
            w_next_state = DEPLOY;
         end
         PLAY: begin
            // A hit wins over a clear detected in the same cycle.
            if (w_hit) begin
               w_next_state = HIT;
            end else if (w_all_down) begin
               w_next_state = CLEAR;
            end else begin
               w_next_state = PLAY;
            end
         end
         HIT: begin
            // r_lives already reflects the hit taken on entry.
            if (r_cnt == HOLD_LAST) begin
               if (r_lives == 3'd0) begin
                  w_next_state = GAME_OVER;
               end else begin
                  w_next_state = DEPLOY;
               end
            end else begin
               w_next_state = HIT;
            end
         end
         CLEAR: begin
            if (r_cnt == HOLD_LAST) begin
               if (r_level == LAST_LEVEL) begin
                  w_next_state = WIN;
               end else begin
                  w_next_state = DEPLOY;
                  w_next_level = r_level + 2'd1;
               end
            end else begin
               w_next_state = CLEAR;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Lives update: reload on start, hit decrements (floor 0), bonus adds (cap 7).
   always_comb begin
      w_lives_sum  = {1'b0, r_lives} + {3'b000, w_bonus};
      w_next_lives = r_lives;
      if (w_start) begin
         w_next_lives = LIVES_LOAD;
      end else if (w_in_play) begin
         if (w_hit && (r_lives != 3'd0)) begin
            w_lives_sum = w_lives_sum - 4'd1;
         end else begin
            w_lives_sum = w_lives_sum;
         end
         if (w_lives_sum > 4'd7) begin
            w_next_lives = 3'd7;
         end else begin
            w_next_lives = w_lives_sum[2:0];
         end
      end else begin
         w_next_lives = r_lives;
      end
   end

   // Unit drive is derived from the upcoming state so it lines up with it.
   always_comb begin
      w_next_entry  = LEVEL_TABLE[w_next_level];
      w_next_armed  = (w_next_state == DEPLOY) || (w_next_state == PLAY);
      w_next_loaded = w_next_armed || (w_next_state == REARM);
   end

   // State, per-state cycle counter, level and lives registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= 32'd0;
         r_level <= 2'd0;
         r_lives <= LIVES_LOAD;
      end else begin
         r_state <= w_next_state;
         if (w_next_state != r_state) begin
            r_cnt <= 32'd0;
         end else begin
            r_cnt <= r_cnt + 32'd1;
         end
         r_level <= w_next_level;
         r_lives <= w_next_lives;
      end
   end

   // Registered unit drive and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_unit_active   <= 2'b00;
         r_initial_state <= '0;
         r_hit_pulse     <= 1'b0;
         r_game_over     <= 1'b0;
         r_level_won     <= 1'b0;
      end else begin
         if (w_next_armed) begin
            r_unit_active <= w_next_entry.mask;
         end else begin
            r_unit_active <= 2'b00;
         end
         if (w_next_loaded) begin
            r_initial_state[0] <= w_next_entry.init0;
            r_initial_state[1] <= w_next_entry.init1;
         end else begin
            r_initial_state <= '0;
         end
         r_hit_pulse <= w_hit;
         if (w_start) begin
            r_game_over <= 1'b0;
            r_level_won <= 1'b0;
         end else begin
            r_game_over <= r_game_over || (w_next_state == GAME_OVER);
            r_level_won <= r_level_won || (w_next_state == WIN);
         end
      end
   end

   score_accumulator u_score (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_start),
      .i_event (w_rope_ev),
      .i_type  (col_ball_type),
      .o_score (score),
      .o_bonus (w_bonus)
   );

   assign unitActive     = r_unit_active;
   assign initialState   = r_initial_state;
   assign lives          = r_lives;
   assign level          = r_level;
   assign playerHitPulse = r_hit_pulse;
   assign gameOver       = r_game_over;
   assign levelWon       = r_level_won;

endmodule

// File: tb/tb_level_manager.sv
// Self-checking bench for level_manager (HIT_HOLD=4, ARM_TIMEOUT=16,
// LIVES_INIT=3). A small ball-controller model raises inUse two cycles after
// unitActive; 'kill' forces inUse low to emulate a cleared or empty field.
module tb_level_manager;

   logic            clk = 1'b0;
   logic            reset;
   logic            startGame;
   logic [1:0]      col_rope_ball;
   logic [1:0][1:0] col_ball_type;
   logic [1:0]      col_player_ball;
   logic [1:0]      inUse;
   logic [1:0]      unitActive;
   logic [1:0][1:0] initialState;
   logic [15:0]     score;
   logic [2:0]      lives;
   logic [1:0]      level;
   logic            playerHitPulse;
   logic            gameOver;
   logic            levelWon;

   int n_checks = 0;
   int n_fail   = 0;
   int m_score  = 0;
   int m_lives  = 3;

   typedef struct {
      int score;
      int lives;
   } exp_t;
   exp_t exp_q[$];

   logic [1:0] ua_d1 = 2'b00;
   logic [1:0] ua_d2 = 2'b00;
   logic [1:0] kill  = 2'b00;

   level_manager #(
      .LIVES_INIT  (3),
      .NUM_LEVELS  (4),
      .HIT_HOLD    (4),
      .ARM_TIMEOUT (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .startGame       (startGame),
      .col_rope_ball   (col_rope_ball),
      .col_ball_type   (col_ball_type),
      .col_player_ball (col_player_ball),
      .inUse           (inUse),
      .unitActive      (unitActive),
      .initialState    (initialState),
      .score           (score),
      .lives           (lives),
      .level           (level),
      .playerHitPulse  (playerHitPulse),
      .gameOver        (gameOver),
      .levelWon        (levelWon)
   );

   always #5 clk = ~clk;

   // Ball controller model: balls become visible two cycles after enable.
   always @(posedge clk) begin
      ua_d1 <= unitActive;
      ua_d2 <= ua_d1;
   end
   assign inUse = ua_d2 & ~kill;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pts(input logic [1:0] t);
      case (t)
         2'd0:    return 50;
         2'd1:    return 100;
         2'd2:    return 200;
         default: return 400;
      endcase
   endfunction

   // Drive one cycle of collision inputs and queue the expected score/lives.
   task automatic drive_pop(input bit live, input logic [1:0] rope,
                            input logic [1:0] t0, input logic [1:0] t1,
                            input logic [1:0] hit);
      int s;
      int l;
      int b;
      s = m_score;
      l = m_lives;
      b = 0;
      if (live) begin
         if (rope[0]) s += pts(t0);
         if (rope[1]) s += pts(t1);
         if (s > 65535) s = 65535;
`ifdef LEVEL_MANAGER_BONUS_LIFE_EN
         if ((s >> 12) > (m_score >> 12)) b = 1;
`endif
         l = m_lives + b;
         if (hit != 2'b00 && m_lives > 0) l = l - 1;
         if (l > 7) l = 7;
      end
      m_score = s;
      m_lives = l;
      exp_q.push_back('{s, l});
      col_rope_ball    = rope;
      col_ball_type[0] = t0;
      col_ball_type[1] = t1;
      col_player_ball  = hit;
      tick();
      col_rope_ball   = 2'b00;
      col_ball_type   = '0;
      col_player_ball = 2'b00;
   endtask

   // Three cycles after unitActive rises the model reports inUse -> PLAY.
   task automatic settle_play();
      repeat (3) tick();
   endtask

   // Count consecutive cycles with unitActive = 0 (bounded).
   task automatic hold_zero(output int n);
      n = 0;
      while (unitActive == 2'b00 && n < 60) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_checks++; if (unitActive !== 2'b00) begin n_fail++; $display("FAIL reset_unitActive: got %b want 00", unitActive); end
      n_checks++; if (initialState !== 4'b0000) begin n_fail++; $display("FAIL reset_initialState: got %b want 0000", initialState); end
      n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
      n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL reset_lives: got %0d want 3", lives); end
      n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
      n_checks++; if ({playerHitPulse, gameOver, levelWon} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {playerHitPulse, gameOver, levelWon}); end
   endtask

   task automatic test_deploy();
      startGame = 1'b1;
      tick();
      startGame = 1'b0;
      m_score = 0;
      m_lives = 3;
      n_checks++; if (unitActive !== 2'b01) begin n_fail++; $display("FAIL deploy_mask: got %b want 01", unitActive); end
      n_checks++; if (initialState[0] !== 2'd1) begin n_fail++; $display("FAIL deploy_init0: got %0d want 1", initialState[0]); end
      n_checks++; if (initialState[1] !== 2'd0) begin n_fail++; $display("FAIL deploy_init1: got %0d want 0", initialState[1]); end
      n_checks++; if (score !== 16'd0 || lives !== 3'd3 || level !== 2'd0) begin n_fail++; $display("FAIL deploy_status: got score %0d lives %0d level %0d want 0/3/0", score, lives, level); end
      settle_play();
      n_checks++; if (unitActive !== 2'b01) begin n_fail++; $display("FAIL play_mask: got %b want 01", unitActive); end
   endtask

   task automatic test_scoring();
      exp_t e;
      drive_pop(1'b1, 2'b11, 2'd3, 2'd0, 2'b00);
      e = exp_q.pop_front();
      n_checks++; if (score !== 16'(e.score)) begin n_fail++; $display("FAIL score_dual: got %0d want %0d", score, e.score); end
      n_checks++; if (score !== 16'd450) begin n_fail++; $display("FAIL score_450: got %0d want 450", score); end
      drive_pop(1'b1, 2'b01, 2'd2, 2'd0, 2'b00);
      e = exp_q.pop_front();
      n_checks++; if (score !== 16'(e.score)) begin n_fail++; $display("FAIL score_single_u0: got %0d want %0d", score, e.score); end
      drive_pop(1'b1, 2'b10, 2'd0, 2'd2, 2'b00);
      e = exp_q.pop_front();
      n_checks++; if (score !== 16'(e.score)) begin n_fail++; $display("FAIL score_single_u1: got %0d want %0d", score, e.score); end
      // startGame outside IDLE/GAME_OVER/WIN must not restart the game.
      startGame = 1'b1;
      drive_pop(1'b1, 2'b00, 2'd0, 2'd0, 2'b00);
      startGame = 1'b0;
      e = exp_q.pop_front();
      n_checks++; if (score !== 16'(e.score) || unitActive !== 2'b01) begin n_fail++; $display("FAIL start_ignored: got score %0d ua %b want %0d 01", score, unitActive, e.score); end
   endtask

   task automatic test_hit();
      exp_t e;
      int n;
      drive_pop(1'b1, 2'b01, 2'd1, 2'd0, 2'b10);
      e = exp_q.pop_front();
      n_checks++; if (score !== 16'(e.score)) begin n_fail++; $display("FAIL hit_score: got %0d want %0d", score, e.score); end
      n_checks++; if (lives !== 3'(e.lives) || lives !== 3'd2) begin n_fail++; $display("FAIL hit_lives: got %0d want %0d", lives, e.lives); end
      n_checks++; if (playerHitPulse !== 1'b1) begin n_fail++; $display("FAIL hit_pulse: got %b want 1", playerHitPulse); end
      // Collisions during HIT must be ignored.
      col_rope_ball   = 2'b11;
      col_ball_type   = 4'b1111;
      col_player_ball = 2'b11;
      tick();
      n_checks++; if (playerHitPulse !== 1'b0) begin n_fail++; $display("FAIL hit_pulse_width: got %b want 0", playerHitPulse); end
      hold_zero(n);
      col_rope_ball   = 2'b00;
      col_ball_type   = '0;
      col_player_ball = 2'b00;
      n = n + 1;
      n_checks++; if (n != 4) begin n_fail++; $display("FAIL hit_hold: got %0d cycles want 4", n); end
      n_checks++; if (unitActive !== 2'b01 || level !== 2'd0 || initialState[0] !== 2'd1) begin n_fail++; $display("FAIL hit_redeploy: got ua %b level %0d init0 %0d want 01 0 1", unitActive, level, initialState[0]); end
      n_checks++; if (score !== 16'(m_score) || lives !== 3'(m_lives)) begin n_fail++; $display("FAIL hit_ignore: got score %0d lives %0d want %0d %0d", score, lives, m_score, m_lives); end
      settle_play();
   endtask

   task automatic test_game_over();
      exp_t e;
      int n;
      // Hit and field-empty in the same cycle: hit takes priority.
      kill = 2'b11;
      drive_pop(1'b1, 2'b00, 2'd0, 2'd0, 2'b01);
      kill = 2'b00;
      e = exp_q.pop_front();
      n_checks++; if (playerHitPulse !== 1'b1 || lives !== 3'(e.lives)) begin n_fail++; $display("FAIL hit_priority: got pulse %b lives %0d want 1 %0d", playerHitPulse, lives, e.lives); end
      hold_zero(n);
      n_checks++; if (n != 4 || level !== 2'd0) begin n_fail++; $display("FAIL hit_priority_level: got hold %0d level %0d want 4 0", n, level); end
      settle_play();
      drive_pop(1'b1, 2'b00, 2'd0, 2'd0, 2'b11);
      e = exp_q.pop_front();
      n_checks++; if (lives !== 3'(e.lives) || lives !== 3'd0) begin n_fail++; $display("FAIL last_life: got %0d want 0", lives); end
      repeat (3) tick();
      n_checks++; if (gameOver !== 1'b0) begin n_fail++; $display("FAIL gameover_early: got %b want 0", gameOver); end
      tick();
      n_checks++; if (gameOver !== 1'b1 || unitActive !== 2'b00) begin n_fail++; $display("FAIL gameover: got go %b ua %b want 1 00", gameOver, unitActive); end
      startGame = 1'b1;
      tick();
      startGame = 1'b0;
      m_score = 0;
      m_lives = 3;
      n_checks++; if (score !== 16'd0 || lives !== 3'd3 || level !== 2'd0 || gameOver !== 1'b0 || unitActive !== 2'b01) begin n_fail++; $display("FAIL restart: got score %0d lives %0d level %0d go %b ua %b want 0 3 0 0 01", score, lives, level, gameOver, unitActive); end
      settle_play();
   endtask

   task automatic test_levels();
      logic [1:0] exp_mask  [4] = '{2'b01, 2'b01, 2'b11, 2'b11};
      logic [1:0] exp_init0 [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
      logic [1:0] exp_init1 [4] = '{2'd0, 2'd0, 2'd2, 2'd2};
      int n;
      for (int lv = 0; lv < 4; lv++) begin
         if (lv == 2) begin
            // Only one of two enabled units empty: not a clear.
            kill = 2'b01;
            tick();
            kill = 2'b00;
            n_checks++; if (unitActive !== 2'b11) begin n_fail++; $display("FAIL partial_clear: got %b want 11", unitActive); end
            tick();
         end
         kill = 2'b11;
         tick();
         kill = 2'b00;
         if (lv < 3) begin
            hold_zero(n);
            n_checks++; if (n != 4) begin n_fail++; $display("FAIL clear_hold_%0d: got %0d want 4", lv, n); end
            n_checks++; if (level !== 2'(lv + 1) || unitActive !== exp_mask[lv + 1]) begin n_fail++; $display("FAIL level_next_%0d: got level %0d mask %b want %0d %b", lv, level, unitActive, lv + 1, exp_mask[lv + 1]); end
            n_checks++; if (initialState[0] !== exp_init0[lv + 1] || initialState[1] !== exp_init1[lv + 1]) begin n_fail++; $display("FAIL level_init_%0d: got %0d/%0d want %0d/%0d", lv, initialState[0], initialState[1], exp_init0[lv + 1], exp_init1[lv + 1]); end
            settle_play();
         end else begin
            repeat (3) tick();
            n_checks++; if (levelWon !== 1'b0) begin n_fail++; $display("FAIL win_early: got %b want 0", levelWon); end
            tick();
            n_checks++; if (levelWon !== 1'b1 || unitActive !== 2'b00 || level !== 2'd3) begin n_fail++; $display("FAIL win: got won %b ua %b level %0d want 1 00 3", levelWon, unitActive, level); end
         end
      end
   endtask

   task automatic test_rearm();
      int n;
      kill = 2'b11;
      startGame = 1'b1;
      tick();
      startGame = 1'b0;
      m_score = 0;
      m_lives = 3;
      n_checks++; if (levelWon !== 1'b0 || unitActive !== 2'b01) begin n_fail++; $display("FAIL win_restart: got won %b ua %b want 0 01", levelWon, unitActive); end
      for (int rep = 0; rep < 2; rep++) begin
         n = 0;
         while (unitActive == 2'b01 && n < 60) begin
            n++;
            tick();
         end
         n_checks++; if (n != 16 || unitActive !== 2'b00) begin n_fail++; $display("FAIL rearm_timeout_%0d: got %0d cycles ua %b want 16 00", rep, n, unitActive); end
         tick();
         n_checks++; if (unitActive !== 2'b01) begin n_fail++; $display("FAIL rearm_retry_%0d: got %b want 01", rep, unitActive); end
      end
      tick();
      tick();
      kill = 2'b00;
      tick();
   endtask

   task automatic test_bonus();
      exp_t e;
      logic [2:0] exp_l;
      for (int i = 0; i < 5; i++) begin
         drive_pop(1'b1, 2'b11, 2'd3, 2'd3, 2'b00);
         e = exp_q.pop_front();
         n_checks++; if (score !== 16'(e.score) || lives !== 3'(e.lives)) begin n_fail++; $display("FAIL pump_%0d: got %0d/%0d want %0d/%0d", i, score, lives, e.score, e.lives); end
      end
      drive_pop(1'b1, 2'b01, 2'd0, 2'd0, 2'b00);
      e = exp_q.pop_front();
      n_checks++; if (score !== 16'd4050) begin n_fail++; $display("FAIL score_4050: got %0d want 4050", score); end
      drive_pop(1'b1, 2'b01, 2'd0, 2'd0, 2'b00);
      e = exp_q.pop_front();
`ifdef LEVEL_MANAGER_BONUS_LIFE_EN
      exp_l = 3'd4;
`else
      exp_l = 3'd3;
`endif
      n_checks++; if (score !== 16'd4100 || lives !== exp_l || lives !== 3'(e.lives)) begin n_fail++; $display("FAIL bonus_cross: got %0d/%0d want 4100/%0d", score, lives, exp_l); end
      for (int i = 0; i < 81; i++) begin
         drive_pop(1'b1, 2'b11, 2'd3, 2'd3, 2'b00);
         e = exp_q.pop_front();
         n_checks++; if (score !== 16'(e.score) || lives !== 3'(e.lives)) begin n_fail++; $display("FAIL sat_%0d: got %0d/%0d want %0d/%0d", i, score, lives, e.score, e.lives); end
      end
      n_checks++; if (score !== 16'hFFFF) begin n_fail++; $display("FAIL saturate: got %h want ffff", score); end
   endtask

   task automatic test_midreset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++; if (score !== 16'd0 || lives !== 3'd3 || level !== 2'd0 || unitActive !== 2'b00 || initialState !== 4'b0000) begin n_fail++; $display("FAIL midreset: got score %0d lives %0d level %0d ua %b init %b want 0 3 0 00 0000", score, lives, level, unitActive, initialState); end
   endtask

   initial begin
      reset           = 1'b1;
      startGame       = 1'b0;
      col_rope_ball   = 2'b00;
      col_ball_type   = '0;
      col_player_ball = 2'b00;
      test_reset();
      test_deploy();
      test_scoring();
      test_hit();
      test_game_over();
      test_levels();
      test_rearm();
      test_bonus();
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
